uart_tx_stream: RTL and testbench

Parametrised, buffered UART transmitter for the FPGA fabric. Accepts words over a valid/ready stream into an internal FIFO and serialises them LSB-first on `tx`, with configurable data width, parity, stop-bit count and baud rate. It replaces single-word fire-and-forget sending: producers may burst up to `FIFO_DEPTH` words without waiting for the line.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 73 +++++++
 rtl/uart_tx_stream.sv | 156 +++++++++++++++
 tb/tb_uart_tx_stream.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and helpers for the UART blocks: FSM state
//               encoding, parity mode constants and the bit-period function.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        UART_IDLE   = 3'd0,
        UART_START  = 3'd1,
        UART_DATA   = 3'd2,
        UART_PARITY = 3'd3,
        UART_STOP   = 3'd4
    } uart_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Clock cycles per line bit, truncated.
    function automatic int cycles_per_bit(input int clock_mhz, input int baud);
        return (clock_mhz * 1000000) / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with occupancy count.
//               clk/rst_n    : clock, asynchronous active-low reset
//               push/push_data: write request and word (ignored when full)
//               pop/rd_data  : read request and head word (ignored when empty)
//               full/empty   : occupancy flags
//               count        : words currently stored
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             w_push;
    logic             w_pop;

    // A push while full is refused even if a pop happens in the same cycle.
    assign w_push  = push && !full;
    assign w_pop   = pop && !empty;
    assign full    = (r_count == c_CW'(DEPTH));
    assign empty   = (r_count == '0);
    assign count   = r_count;
    // Head word; the consumer registers it on the pop edge.
    assign rd_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_stream.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_stream
// Description : Buffered UART transmitter. Words enter over a valid/ready
//               stream into a FIFO and are sent LSB-first on tx.
//               clk/rst_n  : clock, asynchronous active-low reset
//               in_data/in_valid/in_ready : input word stream
//               tx         : serial line, idle high
//               busy       : a frame is in progress
//               fifo_count : words waiting in the FIFO
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_stream
    import uart_pkg::*;
#(
    parameter int CLOCK_SPEED_MHZ = 100,
    parameter int BAUD_RATE       = 9600,
    parameter int DATA_BITS       = 8,
    parameter int PARITY          = 0,
    parameter int STOP_BITS       = 1,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DATA_BITS-1:0]        in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int c_CPB   = cycles_per_bit(CLOCK_SPEED_MHZ, BAUD_RATE);
    localparam int c_CNT_W = (c_CPB > 1) ? $clog2(c_CPB) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(c_CPB - 1);
    localparam logic [3:0]         c_DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]         c_STOP_LAST = 4'(STOP_BITS - 1);

    uart_state_t            r_state;
    uart_state_t            w_next_state;
    logic [c_CNT_W-1:0]     r_baud_cnt;
    logic [3:0]             r_bit_idx;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_parity;
    logic                   r_tx;
    logic                   w_bit_end;
    logic                   w_pop;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic [DATA_BITS-1:0]   w_fifo_rd_data;
    logic                   w_rd_parity;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (w_pop),
        .rd_data   (w_fifo_rd_data),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (fifo_count)
    );

    assign in_ready    = !w_fifo_full;
    assign busy        = (r_state != UART_IDLE);
    assign tx          = r_tx;
    assign w_bit_end   = (r_baud_cnt == c_CNT_LAST);
    // Parity is fixed when the word leaves the FIFO.
    assign w_rd_parity = (PARITY == PAR_ODD) ? ~(^w_fifo_rd_data) : (^w_fifo_rd_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= UART_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        case (r_state)
            UART_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = UART_START;
                end
            end
            UART_START: begin
                if (w_bit_end) begin
                    w_next_state = UART_DATA;
                end
            end
            UART_DATA: begin
                if (w_bit_end && (r_bit_idx == c_DATA_LAST)) begin
                    w_next_state = (PARITY != PAR_NONE) ? UART_PARITY : UART_STOP;
                end
            end
            UART_PARITY: begin
                if (w_bit_end) begin
                    w_next_state = UART_STOP;
                end
            end
            UART_STOP: begin
                if (w_bit_end && (r_bit_idx == c_STOP_LAST)) begin
                    w_next_state = UART_IDLE;
                end
            end
            default: w_next_state = UART_IDLE;
        endcase
    end

    // Baud/bit counters, shift register and the registered line driver.
    // tx follows the state register by one cycle, so every bit keeps its
    // full period on the line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            if (r_state == UART_IDLE) begin
                r_baud_cnt <= '0;
                r_bit_idx  <= '0;
            end else if (w_bit_end) begin
                r_baud_cnt <= '0;
                // Bit index restarts on each state change.
                r_bit_idx  <= (w_next_state != r_state) ? 4'd0 : r_bit_idx + 4'd1;
            end else begin
                r_baud_cnt <= r_baud_cnt + 1'b1;
            end

            if (w_pop) begin
                r_shift  <= w_fifo_rd_data;
                r_parity <= w_rd_parity;
            end else if ((r_state == UART_DATA) && w_bit_end) begin
                r_shift <= r_shift >> 1;
            end

            case (r_state)
                UART_START:  r_tx <= 1'b0;
                UART_DATA:   r_tx <= r_shift[0];
                UART_PARITY: r_tx <= r_parity;
                default:     r_tx <= 1'b1;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_stream
// Description : Self-checking bench for uart_tx_stream at 10 cycles/bit.
//               Instances: 0 = 8N1, 1 = 8E1, 2 = 8O1, 3 = 7N2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [8:0] in_data_v [4];
    logic [3:0] in_valid_v;
    logic [3:0] in_ready_v;
    logic [3:0] tx_v;
    logic [3:0] busy_v;
    logic [4:0] fc_v [4];

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    logic [7:0] rx_q [$];
    int         rx_t [$];
    logic [7:0] exp_q [$];
    logic [7:0] rb;
    int         st;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_stream #(.CLOCK_SPEED_MHZ(1), .BAUD_RATE(100000), .DATA_BITS(8),
                     .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_v[0][7:0]), .in_valid(in_valid_v[0]),
        .in_ready(in_ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .fifo_count(fc_v[0]));

    uart_tx_stream #(.CLOCK_SPEED_MHZ(1), .BAUD_RATE(100000), .DATA_BITS(8),
                     .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_v[1][7:0]), .in_valid(in_valid_v[1]),
        .in_ready(in_ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .fifo_count(fc_v[1]));

    uart_tx_stream #(.CLOCK_SPEED_MHZ(1), .BAUD_RATE(100000), .DATA_BITS(8),
                     .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_v[2][7:0]), .in_valid(in_valid_v[2]),
        .in_ready(in_ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .fifo_count(fc_v[2]));

    uart_tx_stream #(.CLOCK_SPEED_MHZ(1), .BAUD_RATE(100000), .DATA_BITS(7),
                     .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(16)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_v[3][6:0]), .in_valid(in_valid_v[3]),
        .in_ready(in_ready_v[3]), .tx(tx_v[3]), .busy(busy_v[3]), .fifo_count(fc_v[3]));

    // Line receiver for instance 0 (8N1): samples each bit mid-period.
    always begin
        @(posedge clk); #1;
        if (rst_n === 1'b1 && tx_v[0] === 1'b0) begin
            st = cyc;
            repeat (5) begin @(posedge clk); #1; end
            for (int b = 0; b < 8; b++) begin
                repeat (10) begin @(posedge clk); #1; end
                rb[b] = tx_v[0];
            end
            repeat (10) begin @(posedge clk); #1; end
            if (tx_v[0] !== 1'b1) rb = 8'hxx;
            rx_q.push_back(rb);
            rx_t.push_back(st);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_one(input int idx, input logic [8:0] d);
        in_data_v[idx]  = d;
        in_valid_v[idx] = 1'b1;
        tick();
        in_valid_v[idx] = 1'b0;
    endtask

    // Called at the sample point right after the push edge N.
    task automatic check_frame(input int idx, input logic [15:0] bits, input int nbits);
        tick();
        check("start_busy", busy_v[idx], 1'b1);
        check("start_tx_still_high", tx_v[idx], 1'b1);
        for (int k = 0; k < nbits * 10; k++) begin
            tick();
            check($sformatf("frame%0d_tx_k%0d", idx, k), tx_v[idx], bits[k / 10]);
            check($sformatf("frame%0d_busy_k%0d", idx, k), busy_v[idx], (k < nbits * 10 - 1) ? 1 : 0);
        end
        tick();
        check("after_frame_tx", tx_v[idx], 1'b1);
        check("after_frame_busy", busy_v[idx], 1'b0);
    endtask

    task automatic wait_rx(input int n, input int budget);
        for (int c = 0; c < budget && rx_q.size() < n; c++) tick();
        repeat (20) tick();
    endtask

    initial begin
        logic [15:0] fb;
        logic        rdy;
        logic        v;
        logic        flag;
        int          i;
        int          sent;

        rst_n      = 1'b0;
        in_valid_v = 4'b0;
        for (int k = 0; k < 4; k++) in_data_v[k] = 9'h0;
        repeat (3) tick();
        check("reset_tx", tx_v, 4'hF);
        check("reset_busy", busy_v, 4'h0);
        check("reset_ready", in_ready_v, 4'hF);
        check("reset_count", fc_v[0], 5'd0);
        rst_n = 1'b1;
        repeat (3) tick();

        // 8N1, 0xA5
        push_one(0, 9'h0A5);
        check("a5_count_after_push", fc_v[0], 5'd1);
        fb = 16'({1'b1, 8'hA5, 1'b0});
        check_frame(0, fb, 10);

        // 8E1 / 8O1 with 0x07, 7N2 with 0x7F
        push_one(1, 9'h007);
        fb = 16'({1'b1, 1'b1, 8'h07, 1'b0});
        check_frame(1, fb, 11);
        push_one(2, 9'h007);
        fb = 16'({1'b1, 1'b0, 8'h07, 1'b0});
        check_frame(2, fb, 11);
        push_one(3, 9'h07F);
        fb = 16'({2'b11, 7'h7F, 1'b0});
        check_frame(3, fb, 10);

        // Burst with in_valid held; the 18th word probes the full/pop boundary.
        repeat (30) tick();
        rx_q.delete(); rx_t.delete();
        i = 0;
        in_valid_v[0] = 1'b1;
        in_data_v[0]  = 9'h030;
        for (int c = 0; c < 100 && i < 17; c++) begin
            rdy = in_ready_v[0];
            tick();
            if (rdy) begin
                i++;
                in_data_v[0] = 9'(8'h30 + i);
            end
        end
        check("burst_accepted", i, 17);
        check("burst_count_full", fc_v[0], 5'd16);
        check("burst_ready_low", in_ready_v[0], 1'b0);
        for (int c = 0; c < 200 && in_ready_v[0] !== 1'b1; c++) tick();
        check("full_pop_no_push_count", fc_v[0], 5'd15);
        tick();
        in_valid_v[0] = 1'b0;
        check("full_then_push_count", fc_v[0], 5'd16);
        wait_rx(18, 18 * 101 + 300);
        check("burst_rx_words", rx_q.size(), 18);
        for (int j = 0; j < 18 && j < rx_q.size(); j++) begin
            check($sformatf("burst_word%0d", j), rx_q[j], 8'(8'h30 + j));
            if (j > 0) check($sformatf("burst_gap%0d", j), rx_t[j] - rx_t[j-1], 101);
        end

        // Push coincident with a pop at fifo_count=5.
        rx_q.delete(); rx_t.delete();
        in_valid_v[0] = 1'b1;
        for (int j = 0; j < 6; j++) begin
            in_data_v[0] = 9'(8'h50 + j);
            tick();
        end
        in_valid_v[0] = 1'b0;
        check("five_count", fc_v[0], 5'd5);
        flag = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (busy_v[0] === 1'b0) begin flag = 1'b1; break; end
            tick();
        end
        check("five_idle_seen", flag, 1'b1);
        push_one(0, 9'h056);
        check("pushpop_count", fc_v[0], 5'd5);
        check("pushpop_busy", busy_v[0], 1'b1);
        wait_rx(7, 7 * 101 + 300);
        check("pushpop_rx_words", rx_q.size(), 7);
        for (int j = 0; j < 7 && j < rx_q.size(); j++)
            check($sformatf("pushpop_word%0d", j), rx_q[j], 8'(8'h50 + j));

        // Asynchronous reset during data bit 3 with 4 words queued.
        in_valid_v[0] = 1'b1;
        for (int j = 0; j < 5; j++) begin
            in_data_v[0] = 9'(8'h60 + j);
            tick();
        end
        in_valid_v[0] = 1'b0;
        check("prereset_count", fc_v[0], 5'd4);
        repeat (41) tick();
        rst_n = 1'b0;
        #1;
        check("rst_tx", tx_v[0], 1'b1);
        check("rst_busy", busy_v[0], 1'b0);
        check("rst_count", fc_v[0], 5'd0);
        check("rst_ready", in_ready_v[0], 1'b1);
        repeat (2) tick();
        rst_n = 1'b1;
        flag = 1'b0;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) flag = 1'b1;
        end
        check("postreset_line_quiet", flag, 1'b0);
        check("postreset_count", fc_v[0], 5'd0);

        // 200 words with random in_valid, decoded by the receiver.
        rx_q.delete(); rx_t.delete();
        sent = 0;
        for (int c = 0; c < 30000 && sent < 200; c++) begin
            in_valid_v[0] = 1'($urandom_range(0, 1));
            in_data_v[0]  = 9'($urandom_range(0, 255));
            v   = in_valid_v[0];
            rdy = in_ready_v[0];
            tick();
            if (v && rdy) begin
                exp_q.push_back(in_data_v[0][7:0]);
                sent++;
            end
        end
        in_valid_v[0] = 1'b0;
        check("rand_sent", sent, 200);
        wait_rx(200, 25000);
        check("rand_rx_words", rx_q.size(), 200);
        for (int j = 0; j < 200 && j < rx_q.size() && j < exp_q.size(); j++)
            check($sformatf("rand_word%0d", j), rx_q[j], exp_q[j]);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
